// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: UART register map, status bits and arbiter FSM state encoding.
// Revision: 1.0
`default_nettype none

package uart_tx_arbiter_pkg;

  localparam logic [31:0] RX_DATA_OFS  = 32'h0000_0000;
  localparam logic [31:0] TX_DATA_OFS  = 32'h0000_0004;
  localparam logic [31:0] STAT_REG_OFS = 32'h0000_0008;
  localparam logic [31:0] DATA_NUM_OFS = 32'h0000_0010;

  localparam int STAT_TX_FULL  = 3;
  localparam int STAT_TX_EMPTY = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_POLL  = 3'd2,
    ST_CHECK = 3'd3,
    ST_WRITE = 3'd4,
    ST_GUARD = 3'd5
  } state_t;

  function automatic logic tx_can_write(input logic [31:0] stat);
    return stat[STAT_TX_EMPTY] && !stat[STAT_TX_FULL];
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching from ptr+1 with wrap.
// Revision: 1.0
`default_nettype none

module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             found
);

  int cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(ptr) + k) % N_REQ;
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of the UART TX register among byte requesters via a WB master.
// Revision: 1.0
`default_nettype none

module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int          N_REQ       = 3,
  parameter int          GUARD_CYC   = 4,
  parameter int          ACK_TIMEOUT = 64,
  parameter int          LOCK_IDLE   = 256,
  parameter logic [31:0] UART_BASE   = 32'h3000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               o_wb_valid,
  output logic [31:0]        o_wb_adr,
  output logic               o_wb_we,
  output logic [31:0]        o_wb_dat,
  output logic [3:0]         o_wb_sel,
  input  logic               i_wb_ack,
  input  logic [31:0]        i_wb_dat,
  output logic [N_REQ-1:0]   o_grant,
  output logic               o_busy,
  output logic               o_timeout,
  input  logic               i_err_clr
);

  localparam int IW = $clog2(N_REQ);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam int GW = $clog2(GUARD_CYC + 1);
  localparam int LW = $clog2(LOCK_IDLE + 1);

  localparam logic [AW-1:0] ACK_LIM    = AW'(ACK_TIMEOUT);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYC - 1);
  localparam logic [LW-1:0] IDLE_LAST  = LW'(LOCK_IDLE - 1);
  localparam logic [31:0]   STAT_ADR   = UART_BASE + STAT_REG_OFS;
  localparam logic [31:0]   TX_ADR     = UART_BASE + TX_DATA_OFS;

  state_t           state, state_d;
  logic [N_REQ-1:0] grant_q, grant_d, ready_q, ready_d;
  logic [IW-1:0]    owner_q, owner_d, rr_ptr_q, rr_ptr_d;
  logic             lock_q, lock_d, last_q, last_d;
  logic             tx_ok_q, tx_ok_d, timeout_q, timeout_d;
  logic [7:0]       byte_q, byte_d;
  logic [AW-1:0]    ack_cnt_q, ack_cnt_d;
  logic [GW-1:0]    guard_q, guard_d;
  logic [LW-1:0]    idle_q, idle_d;
  logic             abort;

  logic [N_REQ-1:0] arb_grant;
  logic [IW-1:0]    arb_idx;
  logic             arb_found;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .found (arb_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      grant_q   <= '0;
      ready_q   <= '0;
      owner_q   <= '0;
      rr_ptr_q  <= IW'(N_REQ - 1);
      lock_q    <= 1'b0;
      last_q    <= 1'b0;
      tx_ok_q   <= 1'b0;
      timeout_q <= 1'b0;
      byte_q    <= '0;
      ack_cnt_q <= '0;
      guard_q   <= '0;
      idle_q    <= '0;
    end else begin
      state     <= state_d;
      grant_q   <= grant_d;
      ready_q   <= ready_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      lock_q    <= lock_d;
      last_q    <= last_d;
      tx_ok_q   <= tx_ok_d;
      timeout_q <= timeout_d;
      byte_q    <= byte_d;
      ack_cnt_q <= ack_cnt_d;
      guard_q   <= guard_d;
      idle_q    <= idle_d;
    end
  end

  always_comb begin
    state_d   = state;
    grant_d   = grant_q;
    ready_d   = '0;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    lock_d    = lock_q;
    last_d    = last_q;
    tx_ok_d   = tx_ok_q;
    timeout_d = timeout_q;
    byte_d    = byte_q;
    ack_cnt_d = ack_cnt_q;
    guard_d   = guard_q;
    idle_d    = idle_q;
    abort     = 1'b0;

    if (i_err_clr) timeout_d = 1'b0;

    case (state)
      ST_IDLE: begin
        if (|req_valid) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (lock_q) begin
          if (req_valid[owner_q]) begin
            state_d   = ST_POLL;
            idle_d    = '0;
            ack_cnt_d = '0;
          end else if (idle_q >= IDLE_LAST) begin
            lock_d = 1'b0;
            idle_d = '0;
          end else begin
            idle_d = idle_q + LW'(1);
          end
        end else if (arb_found) begin
          grant_d   = arb_grant;
          owner_d   = arb_idx;
          ack_cnt_d = '0;
          state_d   = ST_POLL;
        end else begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      ST_POLL: begin
        if (i_wb_ack) begin
          tx_ok_d = tx_can_write(i_wb_dat);
          state_d = ST_CHECK;
        end else if (ack_cnt_q >= ACK_LIM) begin
          abort = 1'b1;
        end else begin
          ack_cnt_d = ack_cnt_q + AW'(1);
        end
      end
      ST_CHECK: begin
        // One cycle with the strobe low separates successive STAT reads.
        ack_cnt_d = '0;
        if (tx_ok_q) begin
          byte_d  = req_data[{owner_q, 3'b000} +: 8];
          last_d  = req_last[owner_q];
          state_d = ST_WRITE;
        end else begin
          state_d = ST_POLL;
        end
      end
      ST_WRITE: begin
        if (i_wb_ack) begin
          ready_d = grant_q;
          lock_d  = !last_q;
          if (last_q) rr_ptr_d = owner_q;
          guard_d = '0;
          state_d = ST_GUARD;
        end else if (ack_cnt_q >= ACK_LIM) begin
          abort = 1'b1;
        end else begin
          ack_cnt_d = ack_cnt_q + AW'(1);
        end
      end
      ST_GUARD: begin
        if (guard_q == GUARD_LAST) state_d = ST_ARB;
        else                       guard_d = guard_q + GW'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      timeout_d = 1'b1;
      lock_d    = 1'b0;
      grant_d   = '0;
      rr_ptr_d  = owner_q;
      state_d   = ST_IDLE;
    end
  end

  assign o_wb_valid = (state == ST_POLL) || (state == ST_WRITE);
  assign o_wb_we    = (state == ST_WRITE);
  assign o_wb_adr   = (state == ST_POLL)  ? STAT_ADR :
                      (state == ST_WRITE) ? TX_ADR   : 32'h0;
  assign o_wb_dat   = (state == ST_WRITE) ? {24'h0, byte_q} : 32'h0;
  // Full byte select whenever a transaction is on the bus; all-zero at rest so reset leaves every output low.
  assign o_wb_sel   = o_wb_valid ? 4'hF : 4'h0;
  assign o_grant    = grant_q;
  assign req_ready  = ready_q;
  assign o_busy     = (state != ST_IDLE);
  assign o_timeout  = timeout_q;

  logic unused_wb_dat;
  assign unused_wb_dat = ^{i_wb_dat[31:4], i_wb_dat[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with a Wishbone UART slave model and queued byte requesters.
// Revision: 1.0
`default_nettype none

module tb_uart_tx_arbiter;

  localparam int          N          = 3;
  localparam logic [31:0] STAT_ADR   = 32'h3000_0008;
  localparam logic [31:0] TX_ADR     = 32'h3000_0004;
  localparam int          BUSY_CYC   = 20;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [8*N-1:0]   req_data = '0;
  logic [N-1:0]     req_last = '0;
  logic [N-1:0]     req_ready;
  logic             o_wb_valid;
  logic [31:0]      o_wb_adr;
  logic             o_wb_we;
  logic [31:0]      o_wb_dat;
  logic [3:0]       o_wb_sel;
  logic             ack;
  logic [31:0]      rdat;
  logic [N-1:0]     o_grant;
  logic             o_busy;
  logic             o_timeout;
  logic             err_clr = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ       (N),
    .GUARD_CYC   (4),
    .ACK_TIMEOUT (64),
    .LOCK_IDLE   (256),
    .UART_BASE   (32'h3000_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .o_wb_valid (o_wb_valid),
    .o_wb_adr   (o_wb_adr),
    .o_wb_we    (o_wb_we),
    .o_wb_dat   (o_wb_dat),
    .o_wb_sel   (o_wb_sel),
    .i_wb_ack   (ack),
    .i_wb_dat   (rdat),
    .o_grant    (o_grant),
    .o_busy     (o_busy),
    .o_timeout  (o_timeout),
    .i_err_clr  (err_clr)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Slave: 1-cycle ack, TX busy for BUSY_CYC cycles after each write, optional Tx_full polls.
  int busy;
  int sl_reads;
  int full_limit = 0;
  bit no_ack_write = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack      <= 1'b0;
      rdat     <= 32'h0;
      busy     <= 0;
      sl_reads <= 0;
    end else begin
      ack <= 1'b0;
      if (busy != 0) busy <= busy - 1;
      if (o_wb_valid && !ack) begin
        if (o_wb_we) begin
          if (!no_ack_write) begin
            ack  <= 1'b1;
            busy <= BUSY_CYC;
          end
        end else begin
          ack      <= 1'b1;
          sl_reads <= sl_reads + 1;
          if (sl_reads < full_limit) rdat <= 32'h0000_0008;
          else                       rdat <= (busy == 0) ? 32'h0000_0004 : 32'h0000_0000;
        end
      end
    end
  end

  // Requester sources: {last, byte}; front entry is presented until req_ready consumes it.
  logic [8:0] src0[$];
  logic [8:0] src1[$];
  logic [8:0] src2[$];

  always @(posedge clk) begin
    #1;
    if (req_ready[0] && src0.size() > 0) void'(src0.pop_front());
    if (req_ready[1] && src1.size() > 0) void'(src1.pop_front());
    if (req_ready[2] && src2.size() > 0) void'(src2.pop_front());
    req_valid[0] = (src0.size() > 0);
    req_valid[1] = (src1.size() > 0);
    req_valid[2] = (src2.size() > 0);
    if (src0.size() > 0) begin req_data[7:0]   = src0[0][7:0]; req_last[0] = src0[0][8]; end
    if (src1.size() > 0) begin req_data[15:8]  = src1[0][7:0]; req_last[1] = src1[0][8]; end
    if (src2.size() > 0) begin req_data[23:16] = src2[0][7:0]; req_last[2] = src2[0][8]; end
  end

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] b;
  } sb_t;
  sb_t sb[$];

  int reads = 0;
  int writes = 0;
  int wvalid_cycles = 0;
  int rdy_cnt[N];
  int wr_cyc[$];

  initial for (int i = 0; i < N; i++) rdy_cnt[i] = 0;

  always @(negedge clk) begin
    sb_t          e;
    logic [31:0]  exp_dat;
    logic [N-1:0] exp_grant;
    for (int i = 0; i < N; i++) if (req_ready[i]) rdy_cnt[i]++;
    if (o_wb_valid && o_wb_we && !ack) wvalid_cycles++;
    if (o_wb_valid && ack) begin
      tests_run++;
      if (o_wb_we) begin
        writes++;
        wr_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_write: unexpected write dat=%h, none required", o_wb_dat);
        end else begin
          e = sb.pop_front();
          exp_dat = {24'h0, e.b};
          exp_grant = '0;
          exp_grant[e.idx] = 1'b1;
          if (o_wb_dat !== exp_dat || o_wb_adr !== TX_ADR || o_wb_sel !== 4'hF || o_grant !== exp_grant) begin
            tests_failed++;
            $display("FAIL sb_write: dat=%h adr=%h sel=%h grant=%b, required dat=%h adr=%h sel=f grant=%b",
                     o_wb_dat, o_wb_adr, o_wb_sel, o_grant, exp_dat, TX_ADR, exp_grant);
          end
        end
      end else begin
        reads++;
        if (o_wb_adr !== STAT_ADR || o_wb_sel !== 4'hF) begin
          tests_failed++;
          $display("FAIL stat_read: adr=%h sel=%h, required adr=%h sel=f", o_wb_adr, o_wb_sel, STAT_ADR);
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (n < 3000 && !(src0.size() == 0 && src1.size() == 0 && src2.size() == 0 &&
                         sb.size() == 0 && !o_busy)) begin
      @(negedge clk);
      n++;
    end
    tests_run++;
    if (n >= 3000) begin
      tests_failed++;
      $display("FAIL %s_done: busy=%b pending=%0d after 3000 cycles, required idle", name, o_busy, sb.size());
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({o_wb_valid, o_wb_adr, o_wb_we, o_wb_dat, o_wb_sel} !== '0) begin
      tests_failed++;
      $display("FAIL reset_wb: valid=%b adr=%h we=%b dat=%h sel=%h, required all 0",
               o_wb_valid, o_wb_adr, o_wb_we, o_wb_dat, o_wb_sel);
    end
    tests_run++;
    if ({o_grant, o_busy, o_timeout, req_ready} !== '0) begin
      tests_failed++;
      $display("FAIL reset_status: grant=%b busy=%b timeout=%b ready=%b, required all 0",
               o_grant, o_busy, o_timeout, req_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    int r0, w0, k0, k1, k2, n;
    apply_reset();
    r0 = reads; w0 = writes; k0 = rdy_cnt[0]; k1 = rdy_cnt[1]; k2 = rdy_cnt[2];
    src0.push_back({1'b1, 8'hA5});
    sb.push_back('{idx: 2'd0, b: 8'hA5});
    n = 0;
    while (n < 200 && !o_wb_valid) begin @(negedge clk); n++; end
    tests_run++;
    if (o_grant !== 3'b001) begin
      tests_failed++;
      $display("FAIL single_grant: grant=%b, required 001", o_grant);
    end
    wait_done("single");
    tests_run++;
    if (writes - w0 != 1 || reads - r0 < 1) begin
      tests_failed++;
      $display("FAIL single_bus: writes=%0d reads=%0d, required 1 write and >=1 read", writes - w0, reads - r0);
    end
    tests_run++;
    if (rdy_cnt[0] - k0 != 1 || rdy_cnt[1] != k1 || rdy_cnt[2] != k2) begin
      tests_failed++;
      $display("FAIL single_ready: pulses=%0d/%0d/%0d, required 1/0/0",
               rdy_cnt[0] - k0, rdy_cnt[1] - k1, rdy_cnt[2] - k2);
    end
    tests_run++;
    if (o_grant !== 3'b000) begin
      tests_failed++;
      $display("FAIL single_grant_idle: grant=%b, required 000", o_grant);
    end
  endtask

  task automatic test_rr();
    int w0, first, min_gap;
    apply_reset();
    w0 = writes;
    first = wr_cyc.size();
    src0.push_back({1'b1, 8'h10});
    src0.push_back({1'b1, 8'h13});
    src1.push_back({1'b1, 8'h11});
    src2.push_back({1'b1, 8'h12});
    sb.push_back('{idx: 2'd0, b: 8'h10});
    sb.push_back('{idx: 2'd1, b: 8'h11});
    sb.push_back('{idx: 2'd2, b: 8'h12});
    sb.push_back('{idx: 2'd0, b: 8'h13});
    wait_done("rr");
    tests_run++;
    if (writes - w0 != 4) begin
      tests_failed++;
      $display("FAIL rr_count: writes=%0d, required 4", writes - w0);
    end
    min_gap = 1000000;
    for (int i = first + 1; i < wr_cyc.size(); i++)
      if (wr_cyc[i] - wr_cyc[i-1] < min_gap) min_gap = wr_cyc[i] - wr_cyc[i-1];
    tests_run++;
    if (min_gap < BUSY_CYC) begin
      tests_failed++;
      $display("FAIL rr_spacing: min write gap=%0d cycles, required >=%0d", min_gap, BUSY_CYC);
    end
  endtask

  task automatic test_lock();
    int w0, k1, n;
    apply_reset();
    w0 = writes; k1 = rdy_cnt[1];
    src1.push_back({1'b0, 8'h31});
    src1.push_back({1'b0, 8'h32});
    src1.push_back({1'b1, 8'h33});
    sb.push_back('{idx: 2'd1, b: 8'h31});
    sb.push_back('{idx: 2'd1, b: 8'h32});
    sb.push_back('{idx: 2'd1, b: 8'h33});
    n = 0;
    while (n < 500 && rdy_cnt[1] == k1) begin @(negedge clk); n++; end
    src0.push_back({1'b1, 8'h20});
    sb.push_back('{idx: 2'd0, b: 8'h20});
    wait_done("lock");
    tests_run++;
    if (writes - w0 != 4) begin
      tests_failed++;
      $display("FAIL lock_count: writes=%0d, required 4", writes - w0);
    end
  endtask

  task automatic test_full();
    int r0, w0;
    apply_reset();
    full_limit = 10;
    r0 = reads; w0 = writes;
    src2.push_back({1'b1, 8'h5C});
    sb.push_back('{idx: 2'd2, b: 8'h5C});
    wait_done("full");
    tests_run++;
    if (reads - r0 != 11 || writes - w0 != 1) begin
      tests_failed++;
      $display("FAIL full_polls: reads=%0d writes=%0d, required 11 reads and 1 write", reads - r0, writes - w0);
    end
    full_limit = 0;
  endtask

  task automatic test_timeout();
    int w0, k0, v0, n, held;
    apply_reset();
    no_ack_write = 1'b1;
    w0 = writes; k0 = rdy_cnt[0]; v0 = wvalid_cycles;
    src0.push_back({1'b1, 8'h77});
    n = 0;
    while (n < 400 && !o_timeout) begin @(negedge clk); n++; end
    src0.delete();
    held = wvalid_cycles - v0;
    tests_run++;
    if (o_timeout !== 1'b1 || o_wb_valid !== 1'b0 || o_busy !== 1'b0 || o_grant !== 3'b000) begin
      tests_failed++;
      $display("FAIL timeout_abort: timeout=%b valid=%b busy=%b grant=%b, required 1 0 0 000",
               o_timeout, o_wb_valid, o_busy, o_grant);
    end
    tests_run++;
    if (held < 64 || held > 66) begin
      tests_failed++;
      $display("FAIL timeout_len: write strobe held %0d cycles unacked, required 64..66", held);
    end
    tests_run++;
    if (rdy_cnt[0] != k0 || writes != w0) begin
      tests_failed++;
      $display("FAIL timeout_ready: pulses=%0d writes=%0d, required 0 and 0", rdy_cnt[0] - k0, writes - w0);
    end
    repeat (3) @(negedge clk);
    no_ack_write = 1'b0;
    tests_run++;
    if (o_timeout !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_sticky: timeout=%b, required 1", o_timeout);
    end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    tests_run++;
    if (o_timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_clear: timeout=%b, required 0", o_timeout);
    end
  endtask

  task automatic test_reset_mid();
    int w0, k1, n;
    apply_reset();
    w0 = writes; k1 = rdy_cnt[1];
    src1.push_back({1'b1, 8'h3C});
    sb.push_back('{idx: 2'd1, b: 8'h3C});
    n = 0;
    while (n < 300 && !(o_wb_valid && o_wb_we)) begin @(negedge clk); n++; end
    tests_run++;
    if (!(o_wb_valid && o_wb_we)) begin
      tests_failed++;
      $display("FAIL rstmid_reach: valid=%b we=%b, required write in progress", o_wb_valid, o_wb_we);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({o_wb_valid, o_wb_adr, o_wb_we, o_wb_dat, o_wb_sel, o_grant, o_busy, o_timeout, req_ready} !== '0) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: valid=%b adr=%h we=%b dat=%h grant=%b busy=%b ready=%b, required all 0",
               o_wb_valid, o_wb_adr, o_wb_we, o_wb_dat, o_grant, o_busy, req_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_done("rstmid");
    tests_run++;
    if (writes - w0 != 1 || rdy_cnt[1] - k1 != 1) begin
      tests_failed++;
      $display("FAIL rstmid_resend: writes=%0d pulses=%0d, required 1 and 1", writes - w0, rdy_cnt[1] - k1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_lock();
    test_full();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded 500000 time units, required completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
